// File: rtl/stream_test_sequencer.sv
// Run controller for the SDRAM stream test: captures generator words into a
// FWFT FIFO and drains them to the SDRAM write port as bursts.
module stream_test_sequencer #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 24,
  parameter int COUNT_W    = 24
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               gen_en,
  input  logic [31:0]        s32,
  input  logic               n32rdy,
  output logic               wr_req,
  input  logic               wr_ack,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [3:0]         wr_len,
  output logic [31:0]        wr_data,
  input  logic               wr_data_rd,
  output logic               busy,
  output logic               done,
  output logic               overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_FLUSH, S_DONE, S_ERROR
  } state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]      r_wp, r_rp;
  logic [LW-1:0]      r_level;
  logic [COUNT_W-1:0] r_target, r_captured;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_len, r_remain;
  logic               r_req, r_outst;

  logic w_active, w_abort, w_start, w_clear;
  logic w_try, w_push, w_pop, w_full, w_ovf, w_last;
  logic w_ack, w_drain, w_issue;
  logic [3:0] w_issue_len;

  assign w_active = (r_state == S_RUN) || (r_state == S_FLUSH) ||
                    (r_state == S_ERROR);
  assign w_abort  = abort && w_active;
  assign w_start  = start && !abort && (r_state != S_RUN) &&
                    (r_state != S_FLUSH);
  assign w_clear  = w_abort || w_start;

  assign w_try  = (r_state == S_RUN) && n32rdy;
  assign w_pop  = wr_data_rd && r_outst && (r_level != '0);
  assign w_full = (r_level == LW'(FIFO_DEPTH));
  // A same-cycle pop frees the slot, so a push at full is still legal then.
  assign w_ovf  = w_try && w_full && !w_pop;
  assign w_push = w_try && !w_ovf;
  assign w_last = w_push && ((r_captured + COUNT_W'(1)) == r_target);

  assign w_ack   = r_req && wr_ack;
  assign w_drain = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign w_issue = w_drain && !r_req && !r_outst &&
                   ((r_level >= LW'(BURST_LEN)) ||
                    ((r_state == S_FLUSH) && (r_level != '0)));
  assign w_issue_len = (r_level >= LW'(BURST_LEN)) ? 4'(BURST_LEN)
                                                   : 4'(r_level);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_ovf) w_next = S_ERROR;
        else if (w_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if ((r_level == '0) && !r_outst && !r_req) w_next = S_DONE;
      end
      default: ;
    endcase
    if (w_start) w_next = (word_count == '0) ? S_DONE : S_RUN;
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_target   <= '0;
      r_captured <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_remain   <= '0;
      r_req      <= 1'b0;
      r_outst    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_wp     <= '0;
        r_rp     <= '0;
        r_level  <= '0;
        r_req    <= 1'b0;
        r_outst  <= 1'b0;
        r_remain <= '0;
        if (w_start) begin
          r_target   <= word_count;
          r_captured <= '0;
          r_addr     <= base_addr;
        end
      end else begin
        if (w_push) begin
          r_fifo[r_wp] <= s32;
          r_wp         <= r_wp + 1'b1;
          r_captured   <= r_captured + COUNT_W'(1);
        end
        if (w_pop) begin
          r_rp     <= r_rp + 1'b1;
          r_remain <= r_remain - 1'b1;
          if (r_remain == 4'd1) begin
            r_outst <= 1'b0;
            r_addr  <= r_addr + ADDR_W'(r_len);
          end
        end
        if (w_push && !w_pop) r_level <= r_level + 1'b1;
        else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        if (w_ack) begin
          r_req    <= 1'b0;
          r_outst  <= 1'b1;
          r_remain <= r_len;
        end else if (w_issue) begin
          r_req <= 1'b1;
          r_len <= w_issue_len;
        end
      end
    end
  end

  assign gen_en   = (r_state == S_RUN);
  assign wr_req   = r_req;
  assign wr_addr  = r_addr;
  assign wr_len   = r_len;
  assign wr_data  = r_fifo[r_rp];
  assign busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done     = (r_state == S_DONE);
  assign overflow = (r_state == S_ERROR);
endmodule

// File: tb/tb_stream_test_sequencer.sv
// Bench for stream_test_sequencer: generator and SDRAM controller models,
// expected bursts/words queued by the stimulus and checked by the controller.
module tb_stream_test_sequencer;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] word_count = '0;
  logic [23:0] base_addr = '0;
  logic        gen_en;
  logic [31:0] s32;
  logic        n32rdy;
  logic        wr_req;
  logic        wr_ack;
  logic [23:0] wr_addr;
  logic [3:0]  wr_len;
  logic [31:0] wr_data;
  logic        wr_data_rd;
  logic        busy, done, overflow;

  int total = 0;
  int bad = 0;

  logic [27:0] q_burst [$];
  logic [31:0] q_data [$];

  int          g_period = 10;
  int          g_phase = 0;
  int          g_pushes = 0;
  logic [31:0] g_val = '0;

  bit ack_en = 1'b1;
  bit ctl_kill = 1'b0;
  int c_wait = 0;
  int c_left = 0;
  int c_bursts = 0;

  stream_test_sequencer dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .word_count(word_count), .base_addr(base_addr), .gen_en(gen_en),
    .s32(s32), .n32rdy(n32rdy), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_data_rd(wr_data_rd), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got DUT activity want none queued", nm);
  endtask

  // Counter stream generator: strobes every g_period cycles while enabled.
  initial begin
    s32 = '0;
    n32rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_en !== 1'b1) begin
        n32rdy = 1'b0;
        g_phase = 0;
      end else begin
        if (g_phase == 0) begin
          n32rdy = 1'b1;
          s32 = g_val;
          g_val++;
          g_pushes++;
        end else begin
          n32rdy = 1'b0;
        end
        g_phase = (g_phase + 1 >= g_period) ? 0 : g_phase + 1;
      end
    end
  end

  // SDRAM controller model and monitor: acks 2 cycles after req, then pops.
  initial begin
    logic [27:0] e;
    wr_ack = 1'b0;
    wr_data_rd = 1'b0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      wr_data_rd = 1'b0;
      if (n_rst !== 1'b1 || ctl_kill) begin
        c_wait = 0;
        c_left = 0;
        ctl_kill = 1'b0;
        q_burst.delete();
        q_data.delete();
      end else if (c_left > 0) begin
        if (q_data.size() == 0) miss("data_unexpected");
        else chk("wr_data", wr_data, q_data.pop_front());
        wr_data_rd = 1'b1;
        c_left--;
      end else if (wr_req === 1'b1 && ack_en) begin
        if (c_wait == 2) begin
          if (q_burst.size() == 0) begin
            miss("burst_unexpected");
          end else begin
            e = q_burst.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e[27:4]));
            chk("wr_len", 32'(wr_len), 32'(e[3:0]));
          end
          wr_ack = 1'b1;
          c_left = int'(wr_len);
          c_wait = 0;
          c_bursts++;
        end else begin
          c_wait++;
        end
      end else begin
        c_wait = 0;
      end
    end
  end

  task automatic exp_burst(input logic [23:0] a, input logic [3:0] l);
    q_burst.push_back({a, l});
  endtask

  task automatic exp_words(input int n);
    for (int i = 0; i < n; i++) q_data.push_back(32'(i));
  endtask

  task automatic run(input logic [23:0] wc, input logic [23:0] ba,
                     input int per);
    @(negedge clk);
    g_val = '0;
    g_pushes = 0;
    g_period = per;
    word_count = wc;
    base_addr = ba;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_gen_en"}, 32'(gen_en), 32'd0);
    chk({nm, "_wr_req"}, 32'(wr_req), 32'd0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, "_wr_len"}, 32'(wr_len), 32'd0);
    chk({nm, "_wr_data"}, wr_data, 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outs("rst");
    n_rst = 1'b1;

    // two full bursts, slow generator
    exp_burst(24'h000100, 4'd8);
    exp_burst(24'h000108, 4'd8);
    exp_words(16);
    run(24'd16, 24'h000100, 10);
    wait_done("t1_done", 1000);
    chk("t1_pushes", 32'(g_pushes), 32'd16);
    chk("t1_gen_en", 32'(gen_en), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_queues", 32'(q_burst.size() + q_data.size()), 32'd0);

    // partial final burst
    exp_burst(24'h000200, 4'd8);
    exp_burst(24'h000208, 4'd3);
    exp_words(11);
    run(24'd11, 24'h000200, 3);
    wait_done("t2_done", 500);
    chk("t2_pushes", 32'(g_pushes), 32'd11);
    chk("t2_queues", 32'(q_burst.size() + q_data.size()), 32'd0);

    // controller never acks: FIFO fills, 17th strobe overflows
    ack_en = 1'b0;
    run(24'd100, 24'h000500, 2);
    n = 0;
    while (overflow !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_gen_en", 32'(gen_en), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_head", wr_data, 32'd0);
    repeat (2) @(negedge clk);
    chk("t3_pushes", 32'(g_pushes), 32'd17);
    abort = 1'b1;
    ctl_kill = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    chk("t3_req_clr", 32'(wr_req), 32'd0);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    // abort during second burst, then a clean run
    c_bursts = 0;
    exp_burst(24'h000300, 4'd8);
    exp_burst(24'h000308, 4'd8);
    exp_words(16);
    run(24'd32, 24'h000300, 3);
    n = 0;
    while (c_bursts < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_bursts", 32'(c_bursts), 32'd2);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    ctl_kill = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_wr_req", 32'(wr_req), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_gen_en", 32'(gen_en), 32'd0);
    repeat (2) @(negedge clk);
    exp_burst(24'h000400, 4'd8);
    exp_words(8);
    run(24'd8, 24'h000400, 1);
    wait_done("t4b_done", 500);
    chk("t4b_pushes", 32'(g_pushes), 32'd8);
    chk("t4b_queues", 32'(q_burst.size() + q_data.size()), 32'd0);

    // address wrap
    exp_burst(24'hFFFFFC, 4'd8);
    exp_burst(24'h000004, 4'd8);
    exp_words(16);
    run(24'd16, 24'hFFFFFC, 2);
    wait_done("t5_done", 500);
    chk("t5_queues", 32'(q_burst.size() + q_data.size()), 32'd0);

    // zero-length run
    run(24'd0, 24'h000600, 1);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_gen_en", 32'(gen_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_pushes", 32'(g_pushes), 32'd0);

    // asynchronous reset in the middle of a run
    exp_burst(24'h000700, 4'd8);
    exp_burst(24'h000708, 4'd8);
    exp_words(16);
    run(24'd50, 24'h000700, 2);
    repeat (20) @(negedge clk);
    chk("t7_busy_pre", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk_idle_outs("t7");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_test_sequencer.md
# stream_test_sequencer

Run controller for the SDRAM stream test. Sequences the 32-bit counter stream generator for a programmed number of words, buffers the words in an internal FIFO, and hands them to the SDRAM write port as fixed-length bursts at incrementing addresses. Sits between the stream generator and the SDRAM controller write interface and reports run status and overflow to the host/test logic.

## Interface
Parameters:
- BURST_LEN, 8, words per full SDRAM write burst (2..15)
- FIFO_DEPTH, 16, buffer depth in words, power of two, ≥ 2*BURST_LEN
- ADDR_W, 24, SDRAM word address width
- COUNT_W, 24, run length counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run (accepted in IDLE/DONE/ERROR only)
- abort  in  1  one-cycle pulse; terminates run, discards buffered data
- word_count  in  COUNT_W  words to capture, sampled on accepted start
- base_addr  in  ADDR_W  first SDRAM word address, sampled on accepted start
- gen_en  out  1  enable to stream generator
- s32  in  32  generator data word
- n32rdy  in  1  generator word-valid strobe
- wr_req  out  1  burst request to SDRAM controller
- wr_ack  in  1  controller accepts request
- wr_addr  out  ADDR_W  burst start address, stable while wr_req
- wr_len  out  4  burst length in words, stable while wr_req
- wr_data  out  32  FIFO head word (first-word fall-through)
- wr_data_rd  in  1  controller pops one word per asserted cycle
- busy  out  1  high in RUN and FLUSH
- done  out  1  high in DONE
- overflow  out  1  high in ERROR

## Operation
- States: IDLE, RUN, FLUSH, DONE, ERROR.
- IDLE/DONE/ERROR + start: word_count==0 → DONE directly; else latch word_count/base_addr, clear captured count, FIFO, done, overflow → RUN.
- RUN: gen_en=1. Push s32 into FIFO on every cycle with gen_en && n32rdy. When the push making captured==word_count occurs, gen_en=0 from next cycle → FLUSH.
- Push while FIFO full (level==FIFO_DEPTH and no same-cycle pop) → ERROR: word dropped, gen_en=0 next cycle, no new bursts, outstanding burst allowed to complete.
- Burst engine (RUN/FLUSH): when no burst outstanding and level ≥ BURST_LEN, assert wr_req with wr_len=BURST_LEN. In FLUSH with 0 < level < BURST_LEN, wr_len=level (partial final burst).
- wr_req held until wr_ack cycle; drops next cycle. Controller then pops exactly wr_len words; after last pop wr_addr += wr_len (modulo 2^ADDR_W, wraps silently).
- FLUSH → DONE when level==0 and no burst outstanding.
- abort in RUN/FLUSH/ERROR: gen_en=0, FIFO cleared, wr_req dropped, → IDLE next cycle; done/overflow cleared. abort in IDLE/DONE ignored. abort and start same cycle: abort wins.
- Simultaneous push and pop: both happen, level unchanged; legal at full.
- wr_data_rd when FIFO empty or no accepted burst: ignored, no pointer movement.

## Timing
- Reset values: gen_en=0, wr_req=0, wr_addr=0, wr_len=0, wr_data=0 (FIFO contents cleared), busy=0, done=0, overflow=0, state IDLE.
- start → gen_en high on the following cycle; first push possible same cycle gen_en rises (generator strobes immediately when enabled).
- Push at edge N → word visible in level/wr_data after edge N.
- Level crossing BURST_LEN at edge N → wr_req high after edge N+1.
- wr_ack at edge N → wr_req low after edge N; first pop may be in cycle after ack or later.
- Last word pop at edge N → FLUSH→DONE after edge N+1, busy falls with it.
- Overflow detected at edge N → overflow=1, gen_en=0 after edge N.
- Reset mid-run: all state and FIFO cleared immediately, any in-flight burst abandoned.

## Test plan
- word_count=16, base_addr=0x000100, generator period 10, controller acks 2 cycles after req, pops back-to-back → two bursts at 0x000100 and 0x000108, data 0..15 in order, done=1, gen_en low after exactly 16 pushes.
- word_count=11 → bursts len 8 at base, len 3 at base+8, data 0..10, then DONE.
- Controller never acks, word_count=100 → 16 words buffered, 17th strobe → overflow=1, gen_en=0, no further wr_req.
- abort during second burst of word_count=32 run → IDLE next cycle, wr_req=0, FIFO empty, done=0; subsequent start runs cleanly from captured=0.
- base_addr=0xFFFFFC, word_count=16 → bursts at 0xFFFFFC and 0x000004 (wrap).
- start with word_count=0 → DONE next cycle, gen_en never asserted; n_rst pulsed mid-RUN → all outputs return to reset values asynchronously.
